// File: rtl/ldtu_decoder_if.sv
// Word/sample bus of the LDTU decoder: encoded words in, unpacked samples and
// frame status pulses out.
interface ldtu_decoder_if #(
  parameter int Nbits_12 = 12,
  parameter int Nbits_32 = 32
);
  logic [Nbits_32-1:0] DATA32;
  logic                data_valid;
  logic                data_ready;
  logic [Nbits_12:0]   SAMPLE_out;
  logic                sample_valid;
  logic                frame_end;
  logic                crc_err;
  logic                cnt_err;
  logic                illegal_word;

  modport master (
    output DATA32, data_valid,
    input  data_ready, SAMPLE_out, sample_valid, frame_end, crc_err, cnt_err, illegal_word
  );

  modport slave (
    input  DATA32, data_valid,
    output data_ready, SAMPLE_out, sample_valid, frame_end, crc_err, cnt_err, illegal_word
  );
endinterface

// File: rtl/ldtu_decoder.sv
// LDTU word decoder: unpacks baseline/signal words into one sample per cycle and
// checks frame trailers. Define LDTU_DEC_CRC_EN to add the CRC-12 trailer check.
module ldtu_decoder #(
  parameter int Nbits_12 = 12,
  parameter int Nbits_32 = 32
) (
  input logic           CLK,
  input logic           RST,
  ldtu_decoder_if.slave bus
);

  typedef enum logic {IDLE, UNPACK} state_t;

  state_t              state_q, state_d;
  logic [2:0]          pend_q;
  logic [Nbits_32-1:0] word_q;
  logic                base_q;
  logic [7:0]          word_cnt_q;
  logic [Nbits_12:0]   sample_q;
  logic                sample_valid_q;
  logic                frame_end_q;
  logic                cnt_err_q;
  logic                illegal_q;

  logic                ready, accept;
  logic                is_base, is_sig, is_trl, is_idle, is_data;
  logic [2:0]          pend_load;

  function automatic logic [Nbits_12:0] pick(input logic [Nbits_32-1:0] w, input logic base);
    return base ? {{(Nbits_12-5){1'b0}}, w[5:0]} : w[Nbits_12:0];
  endfunction

  always_comb begin
    is_base   = (bus.DATA32[31:30] == 2'b01);
    is_sig    = (bus.DATA32[31:28] == 4'b0010) &&
                ((bus.DATA32[27:26] == 2'b10) || (bus.DATA32[27:26] == 2'b01));
    is_trl    = (bus.DATA32[31:28] == 4'b1101);
    is_idle   = (bus.DATA32 == 32'hEAAA_AAAA);
    is_data   = is_base || is_sig;
    pend_load = is_base ? 3'd5 : ((bus.DATA32[27:26] == 2'b10) ? 3'd2 : 3'd1);
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    if (!RST) ready = (state_q == IDLE) || (pend_q == 3'd1);
    accept  = bus.data_valid && ready;
    case (state_q)
      IDLE:   if (accept && is_data) state_d = UNPACK;
      UNPACK: if ((pend_q == 3'd1) && !(accept && is_data)) state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // The oldest sample is registered on the accepting edge; word_q keeps the rest.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend_q         <= '0;
      word_q         <= '0;
      base_q         <= 1'b0;
      word_cnt_q     <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      frame_end_q    <= 1'b0;
      cnt_err_q      <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      frame_end_q    <= 1'b0;
      cnt_err_q      <= 1'b0;
      illegal_q      <= 1'b0;
      sample_valid_q <= (state_d == UNPACK);

      if (accept && is_data) begin
        sample_q   <= pick(bus.DATA32, is_base);
        word_q     <= is_base ? (bus.DATA32 >> 6) : (bus.DATA32 >> 13);
        base_q     <= is_base;
        pend_q     <= pend_load;
        word_cnt_q <= word_cnt_q + 8'd1;
      end else if (state_q == UNPACK) begin
        if (pend_q > 3'd1) begin
          sample_q <= pick(word_q, base_q);
          word_q   <= base_q ? (word_q >> 6) : (word_q >> 13);
        end
        pend_q <= pend_q - 3'd1;
      end

      if (accept && is_trl) begin
        frame_end_q <= 1'b1;
        cnt_err_q   <= (bus.DATA32[27:20] != word_cnt_q);
        word_cnt_q  <= '0;
      end

      if (accept && !(is_data || is_trl || is_idle)) illegal_q <= 1'b1;
    end
  end

`ifdef LDTU_DEC_CRC_EN
  logic [11:0] crc_q, crc_next;
  logic        crc_err_q;

  // CRC-12 (x^12+x^11+x^3+x^2+x+1), whole word per cycle, MSB first.
  function automatic logic [11:0] crc12_word(input logic [11:0] crc, input logic [31:0] d);
    logic [11:0] c;
    logic        fb;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      fb = c[11] ^ d[i];
      c  = {c[10:0], 1'b0};
      if (fb) c = c ^ 12'h80F;
    end
    return c;
  endfunction

  always_comb crc_next = crc12_word(crc_q, bus.DATA32[31:0]);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      crc_q     <= '0;
      crc_err_q <= 1'b0;
    end else begin
      crc_err_q <= 1'b0;
      if (accept && is_data) crc_q <= crc_next;
      if (accept && is_trl) begin
        crc_err_q <= (bus.DATA32[11:0] != crc_q);
        crc_q     <= '0;
      end
    end
  end

  assign bus.crc_err = crc_err_q;
`else
  assign bus.crc_err = 1'b0;
`endif

  assign bus.data_ready   = ready;
  assign bus.SAMPLE_out   = sample_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.frame_end    = frame_end_q;
  assign bus.cnt_err      = cnt_err_q;
  assign bus.illegal_word = illegal_q;

endmodule

// File: tb/tb_ldtu_decoder.sv
// Directed bench for ldtu_decoder: unpacking, handshake, trailer checks,
// illegal/idle words and mid-unpack reset.
module tb_ldtu_decoder;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  ldtu_decoder_if bus ();

  ldtu_decoder dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

`ifdef LDTU_DEC_CRC_EN
  localparam logic CRC_ON = 1'b1;
`else
  localparam logic CRC_ON = 1'b0;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_smp(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    bus.DATA32     = w;
    bus.data_valid = 1'b1;
    tick();
    bus.data_valid = 1'b0;
  endtask

  function automatic logic [31:0] trailer(input logic [7:0] cnt, input logic [11:0] crc);
    return {4'hD, cnt, 8'h00, crc};
  endfunction

  // Reference CRC as polynomial long division of msg * x^12 by 0x180F.
  function automatic logic [11:0] crc_model(input logic [95:0] msg);
    logic [107:0] r;
    r = {msg, 12'h000};
    for (int i = 107; i >= 12; i--)
      if (r[i]) r[i -: 13] = r[i -: 13] ^ 13'h180F;
    return r[11:0];
  endfunction

  initial begin
    RST            = 1'b1;
    bus.data_valid = 1'b0;
    bus.DATA32     = 32'h0;

    #12;
    check_bit("rst_ready",   bus.data_ready,   1'b0);
    check_bit("rst_valid",   bus.sample_valid, 1'b0);
    check_smp("rst_sample",  bus.SAMPLE_out,   13'h000);
    check_bit("rst_fend",    bus.frame_end,    1'b0);
    check_bit("rst_cnterr",  bus.cnt_err,      1'b0);
    check_bit("rst_crcerr",  bus.crc_err,      1'b0);
    check_bit("rst_illegal", bus.illegal_word, 1'b0);
    tick();
    RST = 1'b0;
    #1;
    check_bit("idle_ready", bus.data_ready, 1'b1);

    // Baseline word, fields 1..5 oldest first
    send(32'h4510_3081);
    check_bit("bl_valid1", bus.sample_valid, 1'b1);
    check_smp("bl_smp1",   bus.SAMPLE_out,   13'h001);
    check_bit("bl_ready1", bus.data_ready,   1'b0);
    for (int i = 2; i <= 5; i++) begin
      tick();
      check_bit("bl_valid", bus.sample_valid, 1'b1);
      check_smp("bl_smp",   bus.SAMPLE_out,   13'(i));
      check_bit("bl_ready", bus.data_ready,   (i == 5));
    end
    tick();
    check_bit("bl_done_valid", bus.sample_valid, 1'b0);
    check_smp("bl_hold",       bus.SAMPLE_out,   13'h005);
    check_bit("bl_done_ready", bus.data_ready,   1'b1);

    // Two-sample signal word, then back-to-back one-sample word, then trailer
    send(32'h2824_7ABC);
    check_smp("sig_smp1",   bus.SAMPLE_out,   13'h1ABC);
    check_bit("sig_ready1", bus.data_ready,   1'b0);
    tick();
    check_smp("sig_smp2",   bus.SAMPLE_out,   13'h0123);
    check_bit("sig_valid2", bus.sample_valid, 1'b1);
    check_bit("sig_ready2", bus.data_ready,   1'b1);
    send(32'h2400_1FFF);
    check_smp("b2b_smp",   bus.SAMPLE_out,   13'h1FFF);
    check_bit("b2b_valid", bus.sample_valid, 1'b1);
    check_bit("b2b_ready", bus.data_ready,   1'b1);
    send(trailer(8'd3, crc_model({32'h4510_3081, 32'h2824_7ABC, 32'h2400_1FFF})));
    check_bit("fr1_fend",   bus.frame_end,    1'b1);
    check_bit("fr1_cnterr", bus.cnt_err,      1'b0);
    check_bit("fr1_crcerr", bus.crc_err,      1'b0);
    check_bit("fr1_valid",  bus.sample_valid, 1'b0);
    check_smp("fr1_hold",   bus.SAMPLE_out,   13'h1FFF);
    tick();
    check_bit("fr1_fend_off", bus.frame_end, 1'b0);

    // Count mismatch: three words, trailer claims four
    send(32'h2400_0001);
    check_smp("cnt_smp1", bus.SAMPLE_out, 13'h0001);
    send(32'h2400_0002);
    send(32'h2400_0003);
    send(trailer(8'd4, crc_model({32'h2400_0001, 32'h2400_0002, 32'h2400_0003})));
    check_bit("fr2_fend",   bus.frame_end, 1'b1);
    check_bit("fr2_cnterr", bus.cnt_err,   1'b1);
    check_bit("fr2_crcerr", bus.crc_err,   1'b0);
    tick();
    check_bit("fr2_cnterr_off", bus.cnt_err, 1'b0);

    // Corrupted CRC field: flagged only when the CRC check is built in
    send(32'h2400_0007);
    send(trailer(8'd1, crc_model({64'h0, 32'h2400_0007}) ^ 12'h001));
    check_bit("fr3_fend",   bus.frame_end, 1'b1);
    check_bit("fr3_cnterr", bus.cnt_err,   1'b0);
    check_bit("fr3_crcerr", bus.crc_err,   CRC_ON);

    // Illegal headers and idle word
    send(32'hF000_0000);
    check_bit("ill1_flag",  bus.illegal_word, 1'b1);
    check_bit("ill1_valid", bus.sample_valid, 1'b0);
    check_bit("ill1_fend",  bus.frame_end,    1'b0);
    tick();
    check_bit("ill1_off", bus.illegal_word, 1'b0);
    send(32'h2C00_0000);
    check_bit("ill2_flag",  bus.illegal_word, 1'b1);
    check_bit("ill2_valid", bus.sample_valid, 1'b0);
    send(32'hEAAA_AAAA);
    check_bit("idle_illegal", bus.illegal_word, 1'b0);
    check_bit("idle_valid",   bus.sample_valid, 1'b0);
    check_bit("idle_fend",    bus.frame_end,    1'b0);
    check_bit("idle_ready2",  bus.data_ready,   1'b1);
    send(32'h2400_0005);
    send(trailer(8'd1, crc_model({64'h0, 32'h2400_0005})));
    check_bit("fr4_fend",   bus.frame_end, 1'b1);
    check_bit("fr4_cnterr", bus.cnt_err,   1'b0);
    check_bit("fr4_crcerr", bus.crc_err,   1'b0);

    // Reset during the third baseline sample
    send(32'h4510_3081);
    tick();
    tick();
    check_smp("rst_mid_smp3", bus.SAMPLE_out, 13'h003);
    #1;
    RST = 1'b1;
    #1;
    check_bit("rst_mid_valid", bus.sample_valid, 1'b0);
    check_bit("rst_mid_ready", bus.data_ready,   1'b0);
    check_smp("rst_mid_smp",   bus.SAMPLE_out,   13'h000);
    #3;
    RST = 1'b0;
    #1;
    check_bit("rel_ready", bus.data_ready,   1'b1);
    check_bit("rel_valid", bus.sample_valid, 1'b0);
    tick();
    check_bit("rel_valid2", bus.sample_valid, 1'b0);
    check_bit("rel_ready2", bus.data_ready,   1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/ldtu_decoder.md
LDTU_DECODER -- requirements
Module: LDTU_decoder

Interface
REQ-001 The block SHALL have these ports: CLK in 1, the sole clock, rising edge; RST in 1, asynchronous active-high reset.
REQ-002 The block SHALL have these input ports: DATA32 in 32, the encoded word from the serializer side; data_valid in 1, DATA32 is valid.
REQ-003 The block SHALL have these output ports: data_ready out 1, a word is accepted when data_valid and data_ready are both 1; SAMPLE_out out 13, bit 12 is the gain flag (1=g01) and bits 11:0 are the sample; sample_valid out 1, SAMPLE_out is valid.
REQ-004 The block SHALL have these output pulse ports: frame_end out 1, one-cycle trailer pulse; crc_err out 1, one-cycle CRC mismatch pulse; cnt_err out 1, one-cycle word-count mismatch pulse; illegal_word out 1, one-cycle unknown-header pulse.
REQ-005 The block SHALL have parameters Nbits_12 (default 12, sample width) and Nbits_32 (default 32, word width).

Function
REQ-006 The block SHALL decode a DATA32 word with header [31:30]=01 as a baseline word carrying five 6-bit samples, the oldest in [5:0]; each sample is output zero-extended with gain flag 0.
REQ-007 The block SHALL decode a DATA32 word with header [31:28]=0010 as a signal word: [27:26]=10 means two samples, [27:26]=01 means one sample; the oldest 13-bit sample is in [12:0] and the second in [25:13].
REQ-008 The block SHALL decode a DATA32 word with header [31:28]=1101 as a frame trailer: [27:20] is the data-word count and [11:0] is CRC-12; a trailer produces no sample.
REQ-009 The block SHALL accept the idle word 0xEAAAAAAA and discard it silently; it produces no sample and does not change the count or CRC.
REQ-010 The block SHALL treat any other header, and a signal word with [27:26] equal to 00 or 11, as illegal: it pulses illegal_word, emits no samples, and excludes the word from the count and CRC.
REQ-011 The block SHALL use a two-state FSM: IDLE (no samples pending) and UNPACK (pending count 1..5 in a 3-bit counter, with the word held in a 32-bit register).
REQ-012 On acceptance of a data word, the block SHALL register it, load the pending count (5, 2 or 1) and go to UNPACK; the first sample appears with sample_valid=1 on the next cycle.
REQ-013 The block SHALL emit exactly one sample per cycle while in UNPACK, oldest first, with no gaps; SAMPLE_out and sample_valid are registered.
REQ-014 The block SHALL drive data_ready combinationally high in IDLE and in UNPACK with pending count 1, giving back-to-back acceptance with no bubble; it is low otherwise.
REQ-015 On the last sample with no new word accepted, the block SHALL return to IDLE; with a new word accepted, it SHALL reload and stay in UNPACK.
REQ-016 The block SHALL count accepted baseline and signal words in an 8-bit counter that wraps modulo 256.
REQ-017 On a trailer, the block SHALL pulse frame_end on the next cycle, pulse cnt_err in the same cycle if [27:20] differs from the counter, then clear the counter and the CRC state.
REQ-018 A trailer accepted on the same edge as the last pending sample SHALL be processed normally; the sample is not lost.
REQ-019 Outside UNPACK, SAMPLE_out SHALL hold its last value and sample_valid SHALL be 0.

Reset
REQ-020 Assertion of RST SHALL asynchronously force state IDLE, pending count 0, word counter 0, CRC 0, SAMPLE_out 0, and sample_valid, frame_end, crc_err, cnt_err and illegal_word to 0.
REQ-021 While RST is asserted, data_ready SHALL be 0; pending samples are discarded when reset asserts mid-UNPACK.

Configuration
REQ-022 With LDTU_DEC_CRC_EN defined, the block SHALL compute CRC-12 (polynomial 0x80F, init 0, 32 bits per cycle, MSB first) over every counted data word, and compare it with trailer [11:0] to pulse crc_err alongside frame_end.
REQ-023 Without LDTU_DEC_CRC_EN, the block SHALL contain no CRC logic, hold crc_err tied to 0, and ignore trailer [11:0].

Verification
REQ-024 Bench SHALL check: baseline word 0x4_0_..., fields 1,2,3,4,5 -> SAMPLE_out 0x001..0x005 on 5 consecutive cycles, first sample 1 cycle after acceptance.
REQ-025 Bench SHALL check: signal word with [27:26]=10, [12:0]=0x1ABC, [25:13]=0x0123 -> 0x1ABC then 0x0123, with data_ready high in the second sample cycle.
REQ-026 Bench SHALL check: 3 data words then a trailer with count 3 and correct CRC -> frame_end pulse, with cnt_err=0 and crc_err=0.
REQ-027 Bench SHALL check: a trailer with count 4 after 3 words -> cnt_err=1 together with frame_end.
REQ-028 Bench SHALL check: header 0xF0000000 -> illegal_word pulse and no sample_valid; 0xEAAAAAAA -> no response.
REQ-029 Bench SHALL check: RST asserted on the 3rd baseline sample -> sample_valid=0 immediately and data_ready=1 after release.
